// File: rtl/step_generator.sv
`timescale 1ns/1ps
// Tempo-driven step sequencer clock.
// A 32-bit phase accumulator advances by the clamped tempo every clock in RUN
// and produces step events. Each event becomes a fixed-width Step pulse
// followed by an equally long low gap. At most one event can wait behind a
// busy pulse. Any further event is dropped and recorded in a sticky Overrun
// flag.
module step_generator #(
    parameter int CLK_HZ         = 50000000,
    parameter int STEPS_PER_BEAT = 4,
    parameter int STEPS_PER_LOOP = 12,
    parameter int STEP_HIGH      = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Play,
    input  logic       Pause,
    input  logic [8:0] Bpm,
    output logic       Step,
    output logic [3:0] StepIndex,
    output logic       Downbeat,
    output logic       Overrun
);

    // Compute the threshold in 64 bits so that CLK_HZ*60 cannot overflow
    // before the division.
    localparam logic [63:0] THRESH_WIDE = 64'(CLK_HZ) * 64'd60 / 64'(STEPS_PER_BEAT);
    localparam logic [31:0] THRESH      = THRESH_WIDE[31:0];

    // The pulse timer counts one full high-plus-gap window. While the value is
    // above STEP_HIGH, Step is in its high half.
    localparam int              CNT_W      = $clog2(2 * STEP_HIGH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2 * STEP_HIGH);
    localparam logic [CNT_W-1:0] CNT_HIGH  = CNT_W'(STEP_HIGH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    localparam logic [3:0] LAST_INDEX = 4'(STEPS_PER_LOOP - 1);
    localparam logic [8:0] BPM_MAX    = 9'd300;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic [3:0]       index_q, index_d;
    logic             downbeat_q, downbeat_d;
    logic             overrun_q, overrun_d;

    logic [8:0]       bpm_eff;
    logic [32:0]      acc_sum;
    logic             acc_hit;
    logic             pulse_free;
    logic [CNT_W-1:0] cnt_decay;

    // Clamp the tempo and precompute the accumulator sum. The sum uses 33 bits
    // so the threshold compare stays exact for any THRESH.
    always_comb begin
        bpm_eff    = (Bpm > BPM_MAX) ? BPM_MAX : Bpm;
        acc_sum    = {1'b0, acc_q} + {24'd0, bpm_eff};
        acc_hit    = (acc_sum >= {1'b0, THRESH});
        // A new rise may be launched once the timer is in the final gap clock
        // or has already expired.
        pulse_free = (cnt_q <= CNT_ONE);
        cnt_decay  = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : CNT_ZERO;
    end

    // Compute the next state, accumulator, pulse scheduling and registered
    // output values.
    always_comb begin
        logic issue;
        logic entry;
        logic event_hit;
        logic clear;

        state_d    = state_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        cnt_d      = cnt_decay;
        index_d    = index_q;
        overrun_d  = overrun_q;
        step_d     = 1'b0;
        downbeat_d = 1'b0;
        issue      = 1'b0;
        entry      = 1'b0;
        event_hit  = 1'b0;
        clear      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Play) begin
                    // Entry step: a fresh loop starts with an immediate pulse
                    // at index 0.
                    state_d = ST_RUN;
                    acc_d   = '0;
                    pend_d  = 1'b0;
                    issue   = 1'b1;
                    entry   = 1'b1;
                end else begin
                    clear = 1'b1;
                end
            end

            ST_RUN: begin
                if (!Play) begin
                    // Stopping takes priority over Pause and over any event
                    // in this cycle.
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end else begin
                    if (acc_hit) begin
                        acc_d     = acc_sum[31:0] - THRESH;
                        event_hit = 1'b1;
                    end else begin
                        acc_d = acc_sum[31:0];
                    end

                    if (Pause) begin
                        state_d = ST_PAUSED;
                    end

                    if (pulse_free && pend_q) begin
                        // Launch the waiting pulse first. An event in this
                        // cycle takes its place in the pending slot.
                        issue  = 1'b1;
                        pend_d = event_hit;
                    end else if (pulse_free && event_hit) begin
                        issue = 1'b1;
                    end else if (event_hit) begin
                        if (pend_q) begin
                            overrun_d = 1'b1;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
            end

            ST_PAUSED: begin
                // Hold the tempo phase and any pending pulse. A running pulse
                // still completes through the timer decay.
                if (!Play) begin
                    state_d = ST_IDLE;
                    clear   = 1'b1;
                end else if (!Pause) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                clear   = 1'b1;
            end
        endcase

        if (clear) begin
            acc_d   = '0;
            pend_d  = 1'b0;
            cnt_d   = CNT_ZERO;
            index_d = 4'd0;
        end

        if (issue) begin
            cnt_d = CNT_FULL;
            if (entry || (index_q == LAST_INDEX)) begin
                index_d = 4'd0;
            end else begin
                index_d = index_q + 4'd1;
            end
        end

        step_d     = (cnt_d > CNT_HIGH);
        downbeat_d = (state_d != ST_IDLE) && (index_d == 4'd0);
    end

    // Register all state and outputs. Reset is synchronous and active-low.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= CNT_ZERO;
            step_q     <= 1'b0;
            index_q    <= 4'd0;
            downbeat_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            index_q    <= index_d;
            downbeat_q <= downbeat_d;
            overrun_q  <= overrun_d;
        end
    end

    assign Step      = step_q;
    assign StepIndex = index_q;
    assign Downbeat  = downbeat_q;
    assign Overrun   = overrun_q;

endmodule

// File: doc/step_generator.md
STEP_GENERATOR -- requirements
Module: step_generator

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: Clock frequency in Hz.
REQ-002 SHALL have parameter STEPS_PER_BEAT, default 4: steps per quarter-note beat.
REQ-003 SHALL have parameter STEPS_PER_LOOP, default 12: steps per pattern loop.
REQ-004 SHALL have parameter STEP_HIGH, default 4: Step pulse high time in clocks, minimum 2.
REQ-005 SHALL have port Clock, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port nReset, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port Play, input, 1 bit: run enable, driven by the loop counter.
REQ-008 SHALL have port Pause, input, 1 bit: freezes tempo phase while high.
REQ-009 SHALL have port Bpm, input, 9 bits: tempo in beats per minute.
REQ-010 SHALL have port Step, output, 1 bit: registered step pulse, consumed by rising-edge detection downstream.
REQ-011 SHALL have port StepIndex, output, 4 bits: current step number, 0..STEPS_PER_LOOP-1.
REQ-012 SHALL have port Downbeat, output, 1 bit: high while in RUN or PAUSED with StepIndex == 0.
REQ-013 SHALL have port Overrun, output, 1 bit: sticky flag for a dropped step event.

Function
REQ-014 SHALL define THRESH = CLK_HZ*60/STEPS_PER_BEAT, computed at elaboration; the phase accumulator SHALL be 32 bits.
REQ-015 SHALL define BpmEff as Bpm clamped to 300; Bpm == 0 SHALL give BpmEff = 0, so no step events occur.
REQ-016 SHALL implement a state machine with states IDLE, RUN and PAUSED; all outputs SHALL be registered.
REQ-017 IDLE SHALL go to RUN on the first clock with Play=1, regardless of Pause; on entry the accumulator SHALL be cleared and an entry step event SHALL be generated.
REQ-018 RUN SHALL go to PAUSED when Pause=1 and Play=1; PAUSED SHALL return to RUN when Pause=0 and Play=1.
REQ-019 In RUN or PAUSED, Play=0 SHALL force IDLE on the next clock; Play=0 has priority over Pause and over any event in that cycle.
REQ-020 In RUN, each clock, the accumulator SHALL apply acc+BpmEff; when acc+BpmEff >= THRESH, the accumulator SHALL load acc+BpmEff-THRESH and a step event SHALL occur in that cycle.
REQ-021 In PAUSED, the accumulator SHALL hold its value, and no new events SHALL occur.
REQ-022 A step event issued at cycle t SHALL drive Step=1 from t+1 for exactly STEP_HIGH clocks, followed by at least STEP_HIGH clocks of Step=0 before the next rise.
REQ-023 An event arriving while a pulse or its low gap is active SHALL set a single pending flag; the pending pulse SHALL rise on the first clock after the gap ends.
REQ-024 An event arriving while pending is already set SHALL be dropped, and Overrun SHALL be set to 1 until reset.
REQ-025 The entry step event SHALL present StepIndex=0; each subsequent issued pulse SHALL increment StepIndex at its rising edge.
REQ-026 StepIndex SHALL wrap from STEPS_PER_LOOP-1 to 0; a dropped event SHALL not advance StepIndex.
REQ-027 A pulse already in progress when PAUSED is entered SHALL complete its full STEP_HIGH time; a pending pulse SHALL be held until RUN resumes.
REQ-028 Entering IDLE SHALL on the next clock give Step=0, StepIndex=0 and Downbeat=0, and SHALL clear the accumulator, pending flag and pulse timers; Overrun SHALL be unaffected.
REQ-029 A Bpm change SHALL take effect on the next accumulator update with no accumulator reset.

Reset
REQ-030 While nReset=0 at a clock edge: state=IDLE, Step=0, StepIndex=0, Downbeat=0, Overrun=0, accumulator=0, pending=0, timers=0.
REQ-031 Reset SHALL take effect mid-pulse and mid-RUN alike, with no partial-pulse completion.
REQ-032 Release of nReset SHALL not generate a step event unless Play=1, in which case REQ-017 applies.

Verification (CLK_HZ=20, STEPS_PER_BEAT=4 giving THRESH=300, STEP_HIGH=2)
REQ-033 Basic run: Bpm=60, Play rises at cycle 0 -> Step rises at cycles 1, 6, 11, ..., each rise high for 2 clocks; StepIndex reads 0,1,2,...; Downbeat is high only while StepIndex=0.
REQ-034 Wrap: run 13 steps at Bpm=60 -> StepIndex goes 11 then 0 at the 13th rise, and Downbeat reasserts.
REQ-035 Stop: Play falls while Step is high -> next clock Step=0 and StepIndex=0; Play rising again restarts at StepIndex=0 with an immediate rise.
REQ-036 Pause: Pause=1 for 20 clocks mid-period at Bpm=60 -> no rises during the pause; the first rise after Pause=0 comes after the remaining accumulator distance, not a full period.
REQ-037 Overrun: Bpm=300 (event every clock) -> one pending pulse issues after the gap, Overrun=1 and stays 1; each issued rise is separated by exactly 2 high and 2 low clocks.
REQ-038 Reset mid-RUN: nReset=0 for one clock during Step high -> all outputs at reset values next clock; with Play held 1, a rise occurs on the clock after release.
